signal_generator: RTL and testbench



---
 rtl/sg_pkg.sv | 16 +
 rtl/sg_wave_shaper.sv | 29 ++
 rtl/signal_generator.sv | 125 ++++++++++++
 tb/tb_signal_generator.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sg_pkg.sv
// Shared types and default widths for the signal_generator burst source.
package sg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sg_state_t;

  localparam int          SG_DATA_W      = 8;
  localparam int          SG_PHASE_W     = 16;
  localparam logic [15:0] SG_PHASE_INC   = 16'h0400;
  localparam int          SG_NUM_SAMPLES = 64;
  localparam int          SG_SAMPLE_DIV  = 1;

endpackage

// File: rtl/sg_wave_shaper.sv
// Combinational phase-to-triangle mapping: the top phase bit folds the
// ramp so one phase period yields 0 -> max -> 0.
module sg_wave_shaper
  import sg_pkg::*;
#(
  parameter int DATA_W  = SG_DATA_W,
  parameter int PHASE_W = SG_PHASE_W
) (
  input  logic [PHASE_W-1:0] phase,
  output logic [DATA_W-1:0]  sample
);

  logic [DATA_W-1:0] ramp;

  // Fold the ramp on the second half of the phase period
  always_comb begin
    ramp   = phase[PHASE_W-2 -: DATA_W];
    sample = phase[PHASE_W-1] ? ~ramp : ramp;
  end

  // Phase bits below the ramp slice only set the fine step and are not used
  generate
    if (PHASE_W > DATA_W + 1) begin : g_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^phase[PHASE_W-DATA_W-2:0];
    end
  endgenerate

endmodule

// File: rtl/signal_generator.sv
// Start-triggered triangle burst generator.
// Optional feature macro: SG_SQUARE_EN adds a registered 'square' output
// (phase MSB captured on each sample tick).
//
// state | meaning
// IDLE  | waiting for a rising edge on start
// RUN   | burst in progress, one sample every SAMPLE_DIV clocks
// DONE  | one-cycle end-of-burst pulse, then back to IDLE
module signal_generator
  import sg_pkg::*;
#(
  parameter int                 DATA_W      = SG_DATA_W,
  parameter int                 PHASE_W     = SG_PHASE_W,
  parameter logic [PHASE_W-1:0] PHASE_INC   = PHASE_W'(SG_PHASE_INC),
  parameter int                 NUM_SAMPLES = SG_NUM_SAMPLES,
  parameter int                 SAMPLE_DIV  = SG_SAMPLE_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
`ifdef SG_SQUARE_EN
  ,
  output logic              square
`endif
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  sg_state_t          state;
  sg_state_t          state_nxt;
  logic               start_q;
  logic               trigger;
  logic               tick;
  logic               last_tick;
  logic [PHASE_W-1:0] phase;
  logic [CNT_W-1:0]   sample_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [DATA_W-1:0]  shaped;

  assign trigger   = start & ~start_q;
  assign tick      = (state == RUN) && (div_cnt == DIV_LAST);
  assign last_tick = tick && (sample_cnt == CNT_LAST);

  sg_wave_shaper #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W)
  ) u_shaper (
    .phase  (phase),
    .sample (shaped)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_tick) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge detect, divider, phase/sample counters and sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= 1'b0;
      phase        <= '0;
      sample_cnt   <= '0;
      div_cnt      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      start_q      <= start;
      sample_valid <= 1'b0;
      if ((state == IDLE) && trigger) begin
        phase      <= '0;
        sample_cnt <= '0;
        div_cnt    <= '0;
      end else if (state == RUN) begin
        if (tick) begin
          sample       <= shaped;
          sample_valid <= 1'b1;
          phase        <= phase + PHASE_INC;
          sample_cnt   <= sample_cnt + 1'b1;
          div_cnt      <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SG_SQUARE_EN
  // Square output tracks the phase MSB of the sample being emitted
  always_ff @(posedge clk) begin
    if (rst)       square <= 1'b0;
    else if (tick) square <= phase[PHASE_W-1];
  end
`endif

endmodule

// File: tb/tb_signal_generator.sv
// Directed bench for signal_generator: one instance with SAMPLE_DIV=1 and
// one with SAMPLE_DIV=4; inputs change and outputs are sampled on negedge.
module tb_signal_generator;
  import sg_pkg::*;

  logic       clk;
  logic       rst;
  logic       start1, start4;
  logic [7:0] s1, s4;
  logic       sv1, sv4, b1, b4, d1, d4;
`ifdef SG_SQUARE_EN
  logic       sq1, sq4;
`endif

  int checks   = 0;
  int failures = 0;

  signal_generator #(.SAMPLE_DIV(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .sample(s1),
    .sample_valid(sv1), .busy(b1), .done(d1)
`ifdef SG_SQUARE_EN
    , .square(sq1)
`endif
  );

  signal_generator #(.SAMPLE_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sample(s4),
    .sample_valid(sv4), .busy(b4), .done(d4)
`ifdef SG_SQUARE_EN
    , .square(sq4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Triangle reference computed arithmetically from the sample index
  function automatic int exp_sample(input int i);
    int ph;
    ph = (i * 1024) % 65536;
    if (ph >= 32768) return 255 - ((ph - 32768) / 128);
    return ph / 128;
  endfunction

  task automatic set_start(input bit sel, input logic val);
    if (sel) start4 = val;
    else     start1 = val;
  endtask

  // Launch a burst on one instance and watch it for ncyc cycles
  task automatic run_burst(input bit sel, input int ncyc, input bit toggle, input string tag);
    int div;
    int strobes;
    int busy_cyc;
    int done_cnt;
    logic v, b, d;
    logic [7:0] s;
    div      = sel ? 4 : 1;
    strobes  = 0;
    busy_cyc = 0;
    done_cnt = 0;
    set_start(sel, 1'b0);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    check({tag, "_busy_at_trigger"}, sel ? b4 : b1, 1);
    for (int c = 0; c < ncyc; c++) begin
      v = sel ? sv4 : sv1;
      b = sel ? b4 : b1;
      d = sel ? d4 : d1;
      s = sel ? s4 : s1;
      if (b) busy_cyc++;
      if (v) begin
        check({tag, "_strobe_time"}, c, div * (strobes + 1));
        check({tag, "_sample"}, s, exp_sample(strobes));
`ifdef SG_SQUARE_EN
        check({tag, "_square"}, sel ? sq4 : sq1, (strobes >= 32) ? 1 : 0);
`endif
        strobes++;
      end
      if (d) begin
        done_cnt++;
        check({tag, "_done_time"}, c, 64 * div);
        check({tag, "_done_with_last_valid"}, v, 1);
        check({tag, "_busy_low_in_done"}, b, 0);
      end
      if (toggle && c == 20) set_start(sel, 1'b0);
      if (toggle && c == 22) set_start(sel, 1'b1);
      @(negedge clk);
    end
    check({tag, "_strobe_count"}, strobes, 64);
    check({tag, "_busy_cycles"}, busy_cyc, 64 * div);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_idle_at_end"}, sel ? b4 : b1, 0);
    check({tag, "_sample_held"}, sel ? s4 : s1, 7);
    set_start(sel, 1'b0);
  endtask

  initial begin
    int strobes;
    int seen_done;
    int seen_busy;

    // Reset with start unknown, then released low
    rst    = 1'b1;
    start1 = 1'bx;
    start4 = 1'bx;
    @(negedge clk);
    rst    = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    check("rst_sample", s1, 0);
    check("rst_valid", sv1, 0);
    check("rst_busy", b1, 0);
    check("rst_done", d1, 0);
    check("rst_state", dut.state, IDLE);
    check("rst4_outputs", {s4, sv4, b4, d4}, 0);
    @(negedge clk);
    check("idle_no_start", {sv1, b1, d1}, 0);

    // Default burst with start held high well past the end
    run_burst(1'b0, 100, 1'b0, "default");

    // Slow divider instance
    run_burst(1'b1, 300, 1'b0, "div4");

    // Start edge during RUN is ignored, then a fresh edge replays the burst
    run_burst(1'b0, 100, 1'b1, "retrig");
    run_burst(1'b0, 100, 1'b0, "second");

    // Reset after the 10th strobe aborts the burst with no done
    start1 = 1'b0;
    @(negedge clk);
    start1  = 1'b1;
    strobes = 0;
    for (int c = 0; c < 40 && strobes < 10; c++) begin
      @(negedge clk);
      if (sv1) strobes++;
    end
    check("mid_reach_10", strobes, 10);
    check("mid_10th_sample", s1, exp_sample(9));
    rst    = 1'b1;
    start1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_sample", s1, 0);
    check("mid_rst_flags", {sv1, b1, d1}, 0);
    check("mid_rst_state", dut.state, IDLE);
    seen_done = 0;
    seen_busy = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (d1) seen_done++;
      if (b1) seen_busy++;
    end
    check("mid_no_done", seen_done, 0);
    check("mid_no_busy", seen_busy, 0);
    run_burst(1'b0, 100, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
